seg16_digit_scanner: RTL

- Time-multiplexing scanner for the 16-segment display bank.
- Holds one 5-bit character code per digit and selects one digit at a time.
- Presents that digit's code to the 16-segment character decoder and drives the matching active-low anode.
- Inserts a blanking interval between digits to suppress ghosting. Sits directly upstream of the decoder; the decoder's segment outputs go to the shared cathode bus.

---
 rtl/seg16_digit_scanner.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/seg16_digit_scanner.sv
// rtl/seg16_digit_scanner.sv - time-multiplexed digit scanner feeding the 16-segment decoder
//
// Holds one 5-bit character code per digit and scans the digits one slot at a time.
// Each slot is BLANK_CYCLES with all anodes off, then SHOW_CYCLES with one anode on.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   enable     in   scan enable; low forces the display dark
//   clear      in   set every buffer entry to the blank code 5'b11111
//   wr_en      in   character buffer write strobe
//   wr_addr    in   digit to write (0 = rightmost); out-of-range addresses are ignored
//   wr_char    in   character code to store
//   char_out   out  code of the active digit, to the decoder char input
//   anode_n    out  one-hot-low digit enables; all ones = dark
//   digit_idx  out  index of the current slot's digit
//   frame_tick out  one-cycle pulse when the scan wraps back to digit 0

module seg16_digit_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int BLANK_CYCLES = 1000,
  parameter int SHOW_CYCLES  = 99000,
  parameter int IDX_W        = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_addr,
  input  logic [4:0]            wr_char,
  output logic [4:0]            char_out,
  output logic [NUM_DIGITS-1:0] anode_n,
  output logic [IDX_W-1:0]      digit_idx,
  output logic                  frame_tick
);

  // One counter serves both phases, so it is sized for the longer one.
  localparam int CNT_MAX = (BLANK_CYCLES > SHOW_CYCLES) ? BLANK_CYCLES : SHOW_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = NUM_DIGITS'(1);

  localparam logic ST_BLANK = 1'b0;
  localparam logic ST_SHOW  = 1'b1;

  logic                  state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4:0]            char_q, char_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic                  tick_q, tick_d;
  logic [4:0]            buf_q [NUM_DIGITS];
  logic [4:0]            buf_d [NUM_DIGITS];

  // Character buffer: clear has priority over a same-cycle write. Matching the
  // address against each valid index drops out-of-range writes for free.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      buf_d[i] = buf_q[i];
      if (clear) begin
        buf_d[i] = 5'b11111;
      end else if (wr_en && (wr_addr == IDX_W'(i))) begin
        buf_d[i] = wr_char;
      end
    end
  end

  // Scan sequencer. char_out is captured only on entry to SHOW so a write to
  // the digit being shown never changes the display mid-slot.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    char_d  = char_q;
    anode_d = anode_q;
    tick_d  = 1'b0;

    if (!enable) begin
      // Dark and parked at the start of BLANK; digit_idx and char_out hold so
      // the scan resumes on the same digit with a full blanking interval.
      state_d = ST_BLANK;
      cnt_d   = '0;
      anode_d = '1;
    end else if (state_q == ST_BLANK) begin
      anode_d = '1;
      if (cnt_q == BLANK_LAST) begin
        state_d = ST_SHOW;
        cnt_d   = '0;
        char_d  = buf_q[idx_q];
        anode_d = ~(ONE_HOT0 << idx_q);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      if (cnt_q == SHOW_LAST) begin
        state_d = ST_BLANK;
        cnt_d   = '0;
        anode_d = '1;
        if (idx_q == IDX_LAST) begin
          idx_d  = '0;
          tick_d = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      idx_q   <= '0;
      char_q  <= 5'b11111;
      anode_q <= '1;
      tick_q  <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        buf_q[i] <= 5'b11111;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      char_q  <= char_d;
      anode_q <= anode_d;
      tick_q  <= tick_d;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

  assign char_out   = char_q;
  assign anode_n    = anode_q;
  assign digit_idx  = idx_q;
  assign frame_tick = tick_q;

endmodule
